mdma_ram_par_wrap: RTL and testbench

Parametrised simple-dual-port RAM wrapper for the DMA datapath: per-byte write enables, per-byte even parity stored alongside data, parity check on read with single/multi-byte error flags, configurable read latency, saturating error counters and write-side parity error injection for test. It replaces fixed-geometry 512b x 512 buffer RAMs and sits between DMA buffer controllers and inferred block RAM.

---
 rtl/mdma_ram_pkg.sv | 32 +++
 rtl/mdma_ram_sdp.sv | 47 ++++
 rtl/mdma_ram_par_wrap.sv | 148 ++++++++++++++
 tb/tb_mdma_ram_par_wrap.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdma_ram_pkg.sv
// Shared definitions for the parity-protected DMA buffer RAM wrapper.
package mdma_ram_pkg;

  // Supported read latencies; the longer one adds an output register stage.
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  // Widest mismatch vector the classifier accepts (covers DATA_W up to 2048).
  localparam int unsigned MAX_NB = 256;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_MULTI  = 2'd2
  } err_class_e;

  // Classify a byte mismatch vector as none / exactly one / two or more set bits.
  function automatic err_class_e err_class(input logic [MAX_NB-1:0] m);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < MAX_NB; i++) begin
      multi = multi | (seen & m[i]);
      seen  = seen | m[i];
    end
    if (multi) return ERR_MULTI;
    if (seen)  return ERR_SINGLE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/mdma_ram_sdp.sv
// Simple-dual-port array: byte-lane writes, registered read-first read port.
module mdma_ram_sdp #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned NB     = DATA_W / 8,
  parameter int unsigned ADR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [ADR_W-1:0]  wadr,
  input  logic [NB-1:0]     wbe,
  input  logic [DATA_W-1:0] wdat,
  input  logic [NB-1:0]     wpar,
  input  logic              ren,
  input  logic [ADR_W-1:0]  radr,
  output logic [DATA_W-1:0] rdat,
  output logic [NB-1:0]     rpar
);

  logic [DATA_W-1:0] mem_dat [DEPTH];
  logic [NB-1:0]     mem_par [DEPTH];

  // Byte-lane write: data byte and its parity bit move together.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wbe[i]) begin
          mem_dat[wadr][8*i +: 8] <= wdat[8*i +: 8];
          mem_par[wadr][i]        <= wpar[i];
        end
      end
    end
  end

  // Read register; sampling old contents gives read-first on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdat <= '0;
      rpar <= '0;
    end else if (ren) begin
      rdat <= mem_dat[radr];
      rpar <= mem_par[radr];
    end
  end

endmodule

// File: rtl/mdma_ram_par_wrap.sv
// Parity-protected DMA buffer RAM: check on read, error counters, parity injection.
module mdma_ram_par_wrap
  import mdma_ram_pkg::*;
#(
  parameter  int unsigned DATA_W = 512,
  parameter  int unsigned DEPTH  = 512,
  parameter  int unsigned RD_LAT = 1,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned ADR_W  = $clog2(DEPTH),
  localparam int unsigned NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [ADR_W-1:0]  wadr,
  input  logic [NB-1:0]     wbe,
  input  logic [DATA_W-1:0] wdat,
  input  logic [NB-1:0]     wpar,
  input  logic              inj_par,
  input  logic              ren,
  input  logic [ADR_W-1:0]  radr,
  output logic              rvld,
  output logic [DATA_W-1:0] rdat,
  output logic [NB-1:0]     rpar,
  output logic              rsbe,
  output logic              rdbe,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  dbe_cnt,
  input  logic              cnt_clr
);

  logic              inj_pend;
  logic              wr_any_c;
  logic [NB-1:0]     low_be_c;
  logic [NB-1:0]     wpar_eff_c;
  logic              ren_q;
  logic [DATA_W-1:0] a_dat;
  logic [NB-1:0]     a_par;
  logic [NB-1:0]     a_calc_c;
  logic [NB-1:0]     mism_c;
  err_class_e        cls_c;
  logic              is_sbe_c;
  logic              is_dbe_c;

  // Injection flips the parity of the lowest enabled lane of the consuming write.
  always_comb begin
    wr_any_c   = wen & (|wbe);
    low_be_c   = wbe & (~wbe + NB'(1));
    wpar_eff_c = wpar ^ (inj_pend ? low_be_c : '0);
  end

  // Pending injection: armed by inj_par, consumed only by a write with lanes enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inj_pend <= 1'b0;
    else        inj_pend <= (inj_pend & ~wr_any_c) | inj_par;
  end

  mdma_ram_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NB     (NB),
    .ADR_W  (ADR_W)
  ) u_sdp (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (wen),
    .wadr  (wadr),
    .wbe   (wbe),
    .wdat  (wdat),
    .wpar  (wpar_eff_c),
    .ren   (ren),
    .radr  (radr),
    .rdat  (a_dat),
    .rpar  (a_par)
  );

  // Tracks which array-register cycles carry a real read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ren_q <= 1'b0;
    else        ren_q <= ren;
  end

  // Recompute byte parity of the array output and classify the mismatch.
  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      a_calc_c[i] = ^a_dat[8*i +: 8];
    end
    mism_c   = a_calc_c ^ a_par;
    cls_c    = err_class(MAX_NB'(mism_c));
    is_sbe_c = (cls_c == ERR_SINGLE);
    is_dbe_c = (cls_c == ERR_MULTI);
  end

  if (RD_LAT == RD_LAT_MAX) begin : gen_lat2
    logic              rvld_q;
    logic [DATA_W-1:0] rdat_q;
    logic [NB-1:0]     rpar_q;
    logic              sbe_q;
    logic              dbe_q;

    // Output stage: data and check result registered together.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvld_q <= 1'b0;
        rdat_q <= '0;
        rpar_q <= '0;
        sbe_q  <= 1'b0;
        dbe_q  <= 1'b0;
      end else begin
        rvld_q <= ren_q;
        sbe_q  <= ren_q & is_sbe_c;
        dbe_q  <= ren_q & is_dbe_c;
        if (ren_q) begin
          rdat_q <= a_dat;
          rpar_q <= a_par;
        end
      end
    end

    assign rvld = rvld_q;
    assign rdat = rdat_q;
    assign rpar = rpar_q;
    assign rsbe = sbe_q;
    assign rdbe = dbe_q;
  end else begin : gen_lat1
    // Outputs straight from the array register; flags gated by valid.
    assign rvld = ren_q;
    assign rdat = a_dat;
    assign rpar = a_par;
    assign rsbe = ren_q & is_sbe_c;
    assign rdbe = ren_q & is_dbe_c;
  end

  // Saturating error counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else if (cnt_clr) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else begin
      if (rsbe && (sbe_cnt != '1)) sbe_cnt <= sbe_cnt + CNT_W'(1);
      if (rdbe && (dbe_cnt != '1)) dbe_cnt <= dbe_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mdma_ram_par_wrap.sv
// Bench: RD_LAT=1 and RD_LAT=2 instances on shared stimulus against a transaction model.
module tb_mdma_ram_par_wrap;

  localparam int unsigned DW  = 512;
  localparam int unsigned DEP = 512;
  localparam int unsigned NBB = DW / 8;
  localparam int unsigned AW  = 9;
  localparam int unsigned CW  = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [NBB-1:0] ALL = {NBB{1'b1}};

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           wen, inj_par, ren, cnt_clr;
  logic [AW-1:0]  wadr, radr;
  logic [NBB-1:0] wbe, wpar;
  logic [DW-1:0]  wdat;

  logic           rvld_o [2];
  logic [DW-1:0]  rdat_o [2];
  logic [NBB-1:0] rpar_o [2];
  logic           rsbe_o [2];
  logic           rdbe_o [2];
  logic [CW-1:0]  sbe_o  [2];
  logic [CW-1:0]  dbe_o  [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdma_ram_par_wrap #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(1), .CNT_W(CW)) u_l1 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wadr(wadr), .wbe(wbe), .wdat(wdat),
    .wpar(wpar), .inj_par(inj_par), .ren(ren), .radr(radr), .rvld(rvld_o[0]),
    .rdat(rdat_o[0]), .rpar(rpar_o[0]), .rsbe(rsbe_o[0]), .rdbe(rdbe_o[0]),
    .sbe_cnt(sbe_o[0]), .dbe_cnt(dbe_o[0]), .cnt_clr(cnt_clr));

  mdma_ram_par_wrap #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(2), .CNT_W(CW)) u_l2 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wadr(wadr), .wbe(wbe), .wdat(wdat),
    .wpar(wpar), .inj_par(inj_par), .ren(ren), .radr(radr), .rvld(rvld_o[1]),
    .rdat(rdat_o[1]), .rpar(rpar_o[1]), .rsbe(rsbe_o[1]), .rdbe(rdbe_o[1]),
    .sbe_cnt(sbe_o[1]), .dbe_cnt(dbe_o[1]), .cnt_clr(cnt_clr));

  // Expected visible read result.
  typedef struct {
    logic           vld;
    logic [DW-1:0]  dat;
    logic [NBB-1:0] par;
    logic           sbe;
    logic           dbe;
  } rd_t;

  // Directed vector: stimulus plus expected read outcome.
  typedef struct {
    string          nm;
    logic           inj;
    logic           wen;
    logic [AW-1:0]  wadr;
    logic [NBB-1:0] wbe;
    logic [7:0]     wfill;
    logic [NBB-1:0] bad;
    logic           ren;
    logic [AW-1:0]  radr;
    logic [7:0]     e_b0;
    logic [7:0]     e_b1;
    logic           e_sbe;
    logic           e_dbe;
  } vec_t;

  // Reference model state.
  logic [DW-1:0]  m_dat [DEP];
  logic [NBB-1:0] m_par [DEP];
  logic           pend;
  rd_t            vis [2];
  rd_t            pipe2;
  int             cs [2];
  int             cd [2];

  function automatic logic [NBB-1:0] bpar(input logic [DW-1:0] d);
    logic [NBB-1:0] p;
    for (int i = 0; i < NBB; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  function automatic rd_t rd_none();
    rd_t r;
    r.vld = 1'b0; r.dat = '0; r.par = '0; r.sbe = 1'b0; r.dbe = 1'b0;
    return r;
  endfunction

  function automatic rd_t adv(input rd_t cur, input rd_t nxt);
    rd_t r;
    if (nxt.vld) return nxt;
    r = cur; r.vld = 1'b0; r.sbe = 1'b0; r.dbe = 1'b0;
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input logic inj, input logic w,
                              input int wa, input logic [NBB-1:0] be, input logic [7:0] fill,
                              input logic [NBB-1:0] bad, input logic r, input int ra,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic es, input logic ed);
    vec_t v;
    v.nm = nm; v.inj = inj; v.wen = w; v.wadr = AW'(wa); v.wbe = be; v.wfill = fill;
    v.bad = bad; v.ren = r; v.radr = AW'(ra); v.e_b0 = b0; v.e_b1 = b1;
    v.e_sbe = es; v.e_dbe = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input int d, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h", nm, d, got, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk("rvld", d, DW'(rvld_o[d]), DW'(vis[d].vld));
      chk("rdat", d, rdat_o[d], vis[d].dat);
      chk("rpar", d, DW'(rpar_o[d]), DW'(vis[d].par));
      chk("rsbe", d, DW'(rsbe_o[d]), DW'(vis[d].sbe));
      chk("rdbe", d, DW'(rdbe_o[d]), DW'(vis[d].dbe));
      chk("sbe_cnt", d, DW'(sbe_o[d]), DW'(cs[d]));
      chk("dbe_cnt", d, DW'(dbe_o[d]), DW'(cd[d]));
    end
  endtask

  task automatic model_reset();
    pend = 1'b0;
    pipe2 = rd_none();
    for (int d = 0; d < 2; d++) begin
      vis[d] = rd_none(); cs[d] = 0; cd[d] = 0;
    end
  endtask

  task automatic set_idle();
    wen = 1'b0; wadr = '0; wbe = '0; wdat = '0; wpar = '0;
    inj_par = 1'b0; ren = 1'b0; radr = '0; cnt_clr = 1'b0;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [NBB-1:0] be,
                        input logic [DW-1:0] d, input logic [NBB-1:0] bad);
    wen = 1'b1; wadr = a; wbe = be; wdat = d; wpar = bpar(d) ^ bad;
  endtask

  // One clock: advance the model with the driven inputs, then compare both DUTs.
  task automatic tick();
    rd_t r;
    rd_t n2;
    logic [NBB-1:0] inj_m;
    int n;
    for (int d = 0; d < 2; d++) begin
      if (cnt_clr) begin
        cs[d] = 0; cd[d] = 0;
      end else begin
        if (vis[d].vld && vis[d].sbe && cs[d] < CMAX) cs[d]++;
        if (vis[d].vld && vis[d].dbe && cd[d] < CMAX) cd[d]++;
      end
    end
    r = rd_none();
    if (ren) begin
      r.vld = 1'b1;
      r.dat = m_dat[radr];
      r.par = m_par[radr];
      n = $countones(bpar(r.dat) ^ r.par);
      r.sbe = (n == 1);
      r.dbe = (n >= 2);
    end
    if (wen && wbe != '0) begin
      inj_m = '0;
      if (pend) begin
        for (int i = NBB - 1; i >= 0; i--) if (wbe[i]) inj_m = NBB'(1) << i;
      end
      for (int i = 0; i < NBB; i++) begin
        if (wbe[i]) begin
          m_dat[wadr][8*i +: 8] = wdat[8*i +: 8];
          m_par[wadr][i] = wpar[i] ^ inj_m[i];
        end
      end
      pend = 1'b0;
    end
    if (inj_par) pend = 1'b1;
    n2 = pipe2;
    pipe2 = r;
    vis[0] = adv(vis[0], r);
    vis[1] = adv(vis[1], n2);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic tchk(input int d, input vec_t v);
    chk({"tv_vld_", v.nm}, d, DW'(rvld_o[d]), DW'(1'b1));
    chk({"tv_b0_", v.nm}, d, DW'(rdat_o[d][7:0]), DW'(v.e_b0));
    chk({"tv_b1_", v.nm}, d, DW'(rdat_o[d][15:8]), DW'(v.e_b1));
    chk({"tv_sbe_", v.nm}, d, DW'(rsbe_o[d]), DW'(v.e_sbe));
    chk({"tv_dbe_", v.nm}, d, DW'(rdbe_o[d]), DW'(v.e_dbe));
  endtask

  vec_t tbl [15];

  initial begin
    logic [DW-1:0] rd;
    logic [NBB-1:0] bad;
    int b;

    tbl[0]  = mk("pw_full",   0, 1, 5, ALL,           8'hFF, '0,  0, 0, 8'h00, 8'h00, 0, 0);
    tbl[1]  = mk("pw_byte0",  0, 1, 5, NBB'(1),       8'h00, '0,  0, 0, 8'h00, 8'h00, 0, 0);
    tbl[2]  = mk("pw_read",   0, 0, 0, '0,            8'h00, '0,  1, 5, 8'h00, 8'hFF, 0, 0);
    tbl[3]  = mk("inj_arm",   1, 0, 0, '0,            8'h00, '0,  0, 0, 8'h00, 8'h00, 0, 0);
    tbl[4]  = mk("inj_wr",    0, 1, 7, ALL,           8'hA5, '0,  0, 0, 8'h00, 8'h00, 0, 0);
    tbl[5]  = mk("inj_rd",    0, 0, 0, '0,            8'h00, '0,  1, 7, 8'hA5, 8'hA5, 1, 0);
    tbl[6]  = mk("dbe_wr",    0, 1, 8, ALL,           8'h3C, NBB'(6), 0, 0, 8'h00, 8'h00, 0, 0);
    tbl[7]  = mk("dbe_rd",    0, 0, 0, '0,            8'h00, '0,  1, 8, 8'h3C, 8'h3C, 0, 1);
    tbl[8]  = mk("col_a",     0, 1, 3, ALL,           8'h11, '0,  0, 0, 8'h00, 8'h00, 0, 0);
    tbl[9]  = mk("col_rw",    0, 1, 3, ALL,           8'h22, '0,  1, 3, 8'h11, 8'h11, 0, 0);
    tbl[10] = mk("col_b",     0, 0, 0, '0,            8'h00, '0,  1, 3, 8'h22, 8'h22, 0, 0);
    tbl[11] = mk("inj_arm2",  1, 0, 0, '0,            8'h00, '0,  0, 0, 8'h00, 8'h00, 0, 0);
    tbl[12] = mk("inj_be0",   0, 1, 9, '0,            8'h77, '0,  0, 0, 8'h00, 8'h00, 0, 0);
    tbl[13] = mk("inj_hi",    0, 1, 9, NBB'(8'hF0),   8'h77, '0,  0, 0, 8'h00, 8'h00, 0, 0);
    tbl[14] = mk("inj_hi_rd", 0, 0, 0, '0,            8'h00, '0,  1, 9, 8'h09, 8'h09, 1, 0);

    set_idle();
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Full write then back-to-back readback.
    for (int i = 0; i < int'(DEP); i++) begin
      set_idle();
      set_wr(AW'(i), ALL, {NBB{8'(i)}}, '0);
      tick();
    end
    for (int i = 0; i < int'(DEP); i++) begin
      set_idle();
      ren = 1'b1; radr = AW'(i);
      tick();
    end
    set_idle();
    tick();
    tick();

    // Directed table.
    for (int k = 0; k < 15; k++) begin
      set_idle();
      inj_par = tbl[k].inj;
      if (tbl[k].wen) set_wr(tbl[k].wadr, tbl[k].wbe, {NBB{tbl[k].wfill}}, tbl[k].bad);
      ren = tbl[k].ren; radr = tbl[k].radr;
      tick();
      if (tbl[k].ren) begin
        tchk(0, tbl[k]);
        set_idle();
        tick();
        tchk(1, tbl[k]);
      end
    end
    set_idle();
    tick();

    // Saturation, then clear racing an error read.
    for (int i = 0; i < 20; i++) begin
      set_idle(); ren = 1'b1; radr = AW'(7);
      tick();
    end
    chk("sat_l1", 0, DW'(sbe_o[0]), DW'(CMAX));
    chk("sat_l2", 1, DW'(sbe_o[1]), DW'(CMAX));
    set_idle(); ren = 1'b1; radr = AW'(7); cnt_clr = 1'b1;
    tick();
    chk("clr_l1", 0, DW'(sbe_o[0]), DW'(0));
    chk("clr_l2", 1, DW'(sbe_o[1]), DW'(0));
    set_idle();
    tick();
    tick();

    // Randomised traffic on a small address window to force collisions.
    for (int t = 0; t < 3000; t++) begin
      set_idle();
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < int'(DW / 32); k++) rd[32*k +: 32] = $urandom;
        b = $urandom_range(0, 7);
        bad = '0;
        if ($urandom_range(0, 9) == 0) bad[$urandom_range(0, NBB - 1)] = 1'b1;
        if ($urandom_range(0, 19) == 0) bad = bad ^ NBB'(3) << $urandom_range(0, NBB - 2);
        set_wr(AW'($urandom_range(0, 15)),
               (b == 0) ? '0 : (b < 3) ? ALL : {$urandom, $urandom}, rd, bad);
      end
      inj_par = ($urandom_range(0, 19) == 0);
      ren     = ($urandom_range(0, 2) != 0);
      radr    = AW'($urandom_range(0, 15));
      cnt_clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    set_idle();
    tick();
    tick();

    // Reset while a read is in flight: nothing may emerge.
    set_idle();
    ren = 1'b1; radr = AW'(7);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    ren = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
